// File: rtl/usb_tx_bit_stuffer.sv
// USB TX bit stuffer: byte handshake in, LSB-first serial bits out,
// a 0 inserted after six consecutive 1s, followed by a 2-bit EOP window.
module usb_tx_bit_stuffer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       stuff_bit_en,
  output logic       bit_en,
  output logic       eop_active,
  output logic       tx_busy,
  output logic       tx_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_STUFF,
    S_EOP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic          shift_last_q, shift_last_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    ones_q, ones_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    buf_q, buf_d;
  logic          buf_last_q, buf_last_d;
  logic          buf_full_q, buf_full_d;
  logic          eop_cnt_q, eop_cnt_d;
  logic          err_q, err_d;

  logic   bit_tick;
  logic   accept;
  logic   drain;
  logic   do_eob;
  state_e eob_state;
  logic   eob_reload;
  logic   eob_err;

  assign bit_tick = (state_q != S_IDLE) && (timer_q == TMAX);
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      pend_q       <= 1'b0;
      timer_q      <= '0;
      buf_q        <= '0;
      buf_last_q   <= 1'b0;
      buf_full_q   <= 1'b0;
      eop_cnt_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      pend_q       <= pend_d;
      timer_q      <= timer_d;
      buf_q        <= buf_d;
      buf_last_q   <= buf_last_d;
      buf_full_q   <= buf_full_d;
      eop_cnt_q    <= eop_cnt_d;
      err_q        <= err_d;
    end
  end

  // What happens once the current byte's eighth bit has gone out
  always_comb begin
    eob_state  = S_EOP;
    eob_reload = 1'b0;
    eob_err    = 1'b0;
    if (!shift_last_q) begin
      if (buf_full_q) begin
        eob_state  = S_SHIFT;
        eob_reload = 1'b1;
      end else begin
        eob_err = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    pend_d       = pend_q;
    eop_cnt_d    = eop_cnt_q;
    err_d        = 1'b0;
    drain        = 1'b0;
    do_eob       = 1'b0;
    if (state_q == S_IDLE || bit_tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          state_d      = S_SHIFT;
          shift_d      = buf_q;
          shift_last_d = buf_last_q;
          drain        = 1'b1;
          bit_cnt_d    = '0;
          ones_d       = '0;
          pend_d       = 1'b0;
        end
      end
      S_SHIFT: begin
        if (bit_tick) begin
          ones_d    = shift_q[0] ? ones_q + 3'd1 : 3'd0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (ones_d == 3'd6) begin
            state_d = S_STUFF;
            pend_d  = (bit_cnt_q == 3'd7);
          end else if (bit_cnt_q == 3'd7) begin
            do_eob = 1'b1;
          end
        end
      end
      S_STUFF: begin
        if (bit_tick) begin
          ones_d = '0;
          if (pend_q) begin
            do_eob = 1'b1;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_EOP: begin
        if (bit_tick) begin
          eop_cnt_d = 1'b1;
          if (eop_cnt_q) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_eob) begin
      state_d   = eob_state;
      err_d     = eob_err;
      eop_cnt_d = 1'b0;
      bit_cnt_d = '0;
      if (eob_reload) begin
        shift_d      = buf_q;
        shift_last_d = buf_last_q;
        drain        = 1'b1;
      end
    end
  end

  always_comb begin
    buf_d      = buf_q;
    buf_last_d = buf_last_q;
    buf_full_d = buf_full_q && !drain;
    if (accept) begin
      buf_d      = tx_data;
      buf_last_d = tx_last;
      buf_full_d = 1'b1;
    end
  end

  always_comb begin
    tx_ready     = !buf_full_q && (state_q != S_EOP);
    serial_out   = 1'b1;
    stuff_bit_en = 1'b0;
    eop_active   = 1'b0;
    tx_busy      = (state_q != S_IDLE);
    bit_en       = bit_tick;
    tx_err       = err_q;
    unique case (state_q)
      S_SHIFT: serial_out = shift_q[0];
      S_STUFF: begin
        serial_out   = 1'b0;
        stuff_bit_en = 1'b1;
      end
      S_EOP:   eop_active = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_bit_stuffer.sv
// Bench for usb_tx_bit_stuffer: directed packets then random ones,
// each bit period compared against a queue built from the stuffing rules.
module tb_usb_tx_bit_stuffer;

  localparam int C = 8;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       serial_out;
  logic       stuff_bit_en;
  logic       bit_en;
  logic       eop_active;
  logic       tx_busy;
  logic       tx_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int err_seen = 0;
  logic [2:0] exp_q[$];

  usb_tx_bit_stuffer #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .serial_out   (serial_out),
    .stuff_bit_en (stuff_bit_en),
    .bit_en       (bit_en),
    .eop_active   (eop_active),
    .tx_busy      (tx_busy),
    .tx_err       (tx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected bit periods {serial, stuff, eop} for one whole packet
  task automatic model_pkt(input bq_t bytes, output int periods);
    int ones;
    logic b;
    ones = 0;
    periods = 0;
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        b = bytes[k][i];
        exp_q.push_back({b, 1'b0, 1'b0});
        periods++;
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          exp_q.push_back(3'b010);
          periods++;
          ones = 0;
        end
      end
    end
    exp_q.push_back(3'b101);
    exp_q.push_back(3'b101);
    periods += 2;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_err) err_seen++;
      if (bit_en) begin
        if (exp_q.size() == 0) chk("extra_bit", 1, 0);
        else chk("bit", {29'd0, serial_out, stuff_bit_en, eop_active},
                 {29'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_pkt(input bq_t bytes, input bit underrun,
                          input bit rnd);
    int periods;
    int t0;
    int w;
    int n;
    n = bytes.size();
    t0 = 0;
    model_pkt(bytes, periods);
    err_seen = 0;
    for (int k = 0; k < n; k++) begin
      if (rnd && k > 0) repeat ($urandom_range(0, 20)) @(negedge clk);
      @(negedge clk);
      tx_data  = bytes[k];
      tx_last  = (k == n - 1) && !underrun;
      tx_valid = 1'b1;
      w = 0;
      while (!tx_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (k == 0) t0 = cyc;
      chk("ready_low", tx_ready, 0);
      if (k == n - 1 || rnd) tx_valid = 1'b0;
    end
    w = 0;
    do begin
      @(posedge clk);
      #1;
      w++;
    end while (tx_busy && w < 5000);
    chk("busy_time", cyc - t0, periods * C + 1);
    chk("err_cnt", err_seen, {31'd0, underrun});
    chk("idle_line", serial_out, 1);
    chk("ready_idle", tx_ready, 1);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, tx_ready, 1);
    chk({tag, "_serial"}, serial_out, 1);
    chk({tag, "_stuff"}, stuff_bit_en, 0);
    chk({tag, "_biten"}, bit_en, 0);
    chk({tag, "_eop"}, eop_active, 0);
    chk({tag, "_busy"}, tx_busy, 0);
    chk({tag, "_err"}, tx_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t bq;
    int periods;
    int w;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_last = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst = 1'b0;

    bq.delete(); bq.push_back(8'h80);
    send_pkt(bq, 0, 0);
    bq.delete(); bq.push_back(8'hFF);
    send_pkt(bq, 0, 0);
    bq.delete(); bq.push_back(8'hF0); bq.push_back(8'h3F);
    send_pkt(bq, 0, 0);
    bq.delete(); bq.push_back(8'h80);
    send_pkt(bq, 1, 0);
    bq.delete(); bq.push_back(8'h12); bq.push_back(8'hFE);
    bq.push_back(8'h7F);
    send_pkt(bq, 0, 0);

    // Abort mid-packet at the fourth bit
    bq.delete(); bq.push_back(8'hA5);
    model_pkt(bq, periods);
    @(negedge clk);
    tx_data = 8'hA5;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    w = 0;
    while (w < 4 * C + 20) begin
      @(negedge clk);
      if (bit_en && exp_q.size() == periods - 4) break;
      w++;
    end
    chk("abort_reach", exp_q.size(), periods - 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_checks("abort");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * C) @(negedge clk);
    chk("abort_no_eop", eop_active, 0);
    chk("abort_idle", tx_busy, 0);

    for (int p = 0; p < 25; p++) begin
      bq.delete();
      for (int k = 0; k < $urandom_range(1, 4); k++) begin
        if ($urandom_range(0, 3) == 0) bq.push_back(8'hFF);
        else bq.push_back(8'($urandom));
      end
      send_pkt(bq, $urandom_range(0, 4) == 0, 1);
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
